// File: rtl/ahb_rr_burst_arbiter.sv
// Output-stage round-robin arbiter for one AHB slave port.
// Fixed-length bursts and locked sequences freeze the grant until they complete.
module ahb_rr_burst_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int PORT_W    = 2
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic [NUM_PORTS-1:0] req_port,
    input  logic                 HREADYM,
    input  logic                 HSELM,
    input  logic [1:0]           HTRANSM,
    input  logic [2:0]           HBURSTM,
    input  logic                 HMASTLOCKM,
    output logic [PORT_W-1:0]    addr_in_port,
    output logic                 no_port,
    output logic                 burst_hold
);
    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_BUSY   = 2'b01;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;
    localparam logic [PORT_W-1:0] LAST_IDX = PORT_W'(NUM_PORTS - 1);

    logic [4:0]        beat_cnt;
    logic [4:0]        cnt_nxt;
    logic [4:0]        burst_len;
    logic [PORT_W-1:0] last_grant;
    logic [PORT_W-1:0] winner;
    logic [PORT_W-1:0] idx;
    logic              found;
    logic              hold;

    always_comb begin
        case (HBURSTM)
            3'b010, 3'b011: burst_len = 5'd4;
            3'b100, 3'b101: burst_len = 5'd8;
            3'b110, 3'b111: burst_len = 5'd16;
            default:        burst_len = 5'd1;
        endcase
    end

    // Beats still owed by the burst once the current address phase is accepted.
    always_comb begin
        cnt_nxt = 5'd0;
        if (HSELM) begin
            case (HTRANSM)
                TRANS_NONSEQ: cnt_nxt = burst_len - 5'd1;
                TRANS_SEQ:    cnt_nxt = (beat_cnt != 5'd0) ? beat_cnt - 5'd1 : 5'd0;
                TRANS_BUSY:   cnt_nxt = beat_cnt;
                TRANS_IDLE:   cnt_nxt = 5'd0;
                default:      cnt_nxt = 5'd0;
            endcase
        end
        hold = HMASTLOCKM | (cnt_nxt != 5'd0);
    end

    // Walk from the port after the last winner; wrap by compare so that
    // non-power-of-two port counts never yield an out-of-range index.
    always_comb begin
        winner = last_grant;
        found  = 1'b0;
        idx    = last_grant;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (idx == LAST_IDX) idx = '0;
            else                 idx = idx + 1'b1;
            if (!found && req_port[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_in_port <= '0;
            no_port      <= 1'b1;
            burst_hold   <= 1'b0;
            last_grant   <= LAST_IDX;
            beat_cnt     <= 5'd0;
        end else if (HREADYM) begin
            beat_cnt   <= cnt_nxt;
            burst_hold <= hold;
            if (!hold) begin
                if (found) begin
                    addr_in_port <= winner;
                    last_grant   <= winner;
                    no_port      <= 1'b0;
                end else begin
                    no_port <= ~HSELM;
                end
            end
        end
    end
endmodule
